ps2_command_sequencer: RTL and testbench

Master for the ps2_controller MMIO port. It sits between the CPU-side keyboard/mouse driver logic and ps2_controller. It drains device bytes from the controller FIFO into a ready/valid scan stream. It also executes host commands (command byte plus optional argument byte) with ACK (0xFA) and RESEND (0xFE) handling, bounded retries and a response timeout. This gives the rest of the system a byte-stream interface in place of MMIO polling.

---
 rtl/ps2_command_sequencer_if.sv | 22 ++
 rtl/ps2_command_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_command_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_command_sequencer_if.sv
// MMIO bus between ps2_command_sequencer (master) and ps2_controller (slave).
// The signal names match the sequencer's original MMIO port names.
interface ps2_command_sequencer_if;
  logic [2:0] address_mmio;
  logic [7:0] data_write_mmio;
  logic       is_mmio_write;
  logic [7:0] data_read_mmio;

  modport master (
    output address_mmio,
    output data_write_mmio,
    output is_mmio_write,
    input  data_read_mmio
  );

  modport slave (
    input  address_mmio,
    input  data_write_mmio,
    input  is_mmio_write,
    output data_read_mmio
  );
endinterface

// File: rtl/ps2_command_sequencer.sv
// Drains ps2_controller's receive FIFO into a ready/valid scan stream and runs
// host commands (cmd + optional arg) with ACK/RESEND handling and a timeout.
module ps2_command_sequencer #(
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1660000,
  parameter int unsigned MAX_RESEND         = 3
) (
  input  logic       main_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       done,
  output logic [1:0] done_status,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic [7:0] scan_byte,
  output logic       scan_parity_err,
  output logic       stray_resp,
  ps2_command_sequencer_if.master mmio
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT_CYCLES + 1);
  localparam int unsigned RS_W  = $clog2(MAX_RESEND + 2);

  localparam logic [2:0] A_DATA   = 3'b000;
  localparam logic [2:0] A_TXDATA = 3'b001;
  localparam logic [2:0] A_STATUS = 3'b010;
  localparam logic [2:0] A_TXBUSY = 3'b011;
  localparam logic [2:0] A_PARITY = 3'b100;

  typedef enum logic [2:0] {
    M_POLL, M_RD_DATA, M_RD_PAR, M_POP, M_CLASSIFY, M_EMIT, M_TX_CHK, M_TX_WR
  } main_e;

  typedef enum logic [2:0] {
    C_IDLE, C_SEND_CMD, C_WAIT_CMD, C_SEND_ARG, C_WAIT_ARG, C_FINISH
  } cmd_e;

  main_e            main_q, main_d;
  cmd_e             cmd_q, cmd_d;
  logic [1:0]       rd_cnt_q, rd_cnt_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_par_q, rx_par_d;
  logic [2:0]       addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             scan_valid_q, scan_valid_d;
  logic [7:0]       scan_byte_q, scan_byte_d;
  logic             scan_par_q, scan_par_d;
  logic             stray_q, stray_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [7:0]       cbyte_q, cbyte_d;
  logic [7:0]       carg_q, carg_d;
  logic             chas_q, chas_d;
  logic [1:0]       status_q, status_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RS_W-1:0]  rs_q, rs_d;

  logic rd_state, rd_done, send_pending, waiting, classify, is_ack, is_nak;
  logic [7:0] tx_byte;

  always_comb begin
    rd_state     = (main_q == M_POLL) || (main_q == M_RD_DATA) ||
                   (main_q == M_RD_PAR) || (main_q == M_TX_CHK);
    rd_done      = rd_state && (rd_cnt_q == 2'd2);
    send_pending = (cmd_q == C_SEND_CMD) || (cmd_q == C_SEND_ARG);
    waiting      = (cmd_q == C_WAIT_CMD) || (cmd_q == C_WAIT_ARG);
    classify     = (main_q == M_CLASSIFY);
    is_ack       = (rx_byte_q == 8'hFA);
    is_nak       = (rx_byte_q == 8'hFE);
    tx_byte      = (cmd_q == C_SEND_ARG) ? carg_q : cbyte_q;
  end

  // Main loop: every read holds its address for 3 cycles and samples on the third.
  always_comb begin
    main_d       = main_q;
    rx_byte_d    = rx_byte_q;
    rx_par_d     = rx_par_q;
    scan_valid_d = scan_valid_q;
    scan_byte_d  = scan_byte_q;
    scan_par_d   = scan_par_q;
    case (main_q)
      M_POLL:
        if (rd_done) begin
          if (mmio.data_read_mmio[0] && !scan_valid_q) main_d = M_RD_DATA;
          else if (send_pending)                       main_d = M_TX_CHK;
          else                                         main_d = M_POLL;
        end
      M_RD_DATA:
        if (rd_done) begin
          rx_byte_d = mmio.data_read_mmio;
          main_d    = M_RD_PAR;
        end
      M_RD_PAR:
        if (rd_done) begin
          rx_par_d = mmio.data_read_mmio[0];
          main_d   = M_POP;
        end
      M_POP:      main_d = M_CLASSIFY;
      M_CLASSIFY: main_d = (is_ack || is_nak) ? M_POLL : M_EMIT;
      M_EMIT: begin
        scan_valid_d = 1'b1;
        scan_byte_d  = rx_byte_q;
        scan_par_d   = rx_par_q;
        main_d       = M_POLL;
      end
      M_TX_CHK:
        if (rd_done) main_d = (mmio.data_read_mmio == 8'h00) ? M_TX_WR : M_POLL;
      M_TX_WR:    main_d = M_POLL;
      default:    main_d = M_POLL;
    endcase
    if (scan_valid_q && scan_ready) scan_valid_d = 1'b0;

    rd_cnt_d = (rd_state && !rd_done) ? rd_cnt_q + 2'd1 : 2'd0;

    // Bus outputs are registered from the next state so they line up with it.
    case (main_d)
      M_RD_DATA: addr_d = A_DATA;
      M_RD_PAR:  addr_d = A_PARITY;
      M_POP:     addr_d = A_DATA;
      M_TX_CHK:  addr_d = A_TXBUSY;
      M_TX_WR:   addr_d = A_TXDATA;
      default:   addr_d = A_STATUS;
    endcase
    wr_d    = (main_d == M_POP) || (main_d == M_TX_WR);
    wdata_d = (main_d == M_TX_WR) ? tx_byte : 8'h00;
    stray_d = classify && (is_ack || is_nak) && !waiting;
  end

  // Command sub-state; a response byte classified this cycle beats the timeout.
  always_comb begin
    cmd_d    = cmd_q;
    cbyte_d  = cbyte_q;
    carg_d   = carg_q;
    chas_d   = chas_q;
    status_d = status_q;
    rs_d     = rs_q;
    timer_d  = timer_q;
    if (waiting && (timer_q != '0)) timer_d = timer_q - TMR_W'(1);
    case (cmd_q)
      C_IDLE:
        if (cmd_valid && cmd_ready_q) begin
          cbyte_d = cmd_byte;
          carg_d  = cmd_arg;
          chas_d  = cmd_has_arg;
          rs_d    = '0;
          cmd_d   = C_SEND_CMD;
        end
      C_SEND_CMD, C_SEND_ARG:
        if (main_q == M_TX_WR) begin
          timer_d = TMR_W'(ACK_TIMEOUT_CYCLES);
          cmd_d   = (cmd_q == C_SEND_CMD) ? C_WAIT_CMD : C_WAIT_ARG;
        end
      C_WAIT_CMD, C_WAIT_ARG:
        if (classify && is_ack) begin
          if ((cmd_q == C_WAIT_CMD) && chas_q) begin
            rs_d  = '0;
            cmd_d = C_SEND_ARG;
          end else begin
            status_d = 2'd0;
            cmd_d    = C_FINISH;
          end
        end else if (classify && is_nak) begin
          if (rs_q == RS_W'(MAX_RESEND)) begin
            status_d = 2'd1;
            cmd_d    = C_FINISH;
          end else begin
            rs_d  = rs_q + RS_W'(1);
            cmd_d = (cmd_q == C_WAIT_CMD) ? C_SEND_CMD : C_SEND_ARG;
          end
        end else if (timer_q == '0) begin
          status_d = 2'd2;
          cmd_d    = C_FINISH;
        end
      C_FINISH: cmd_d = C_IDLE;
      default:  cmd_d = C_IDLE;
    endcase
    cmd_ready_d = (cmd_d == C_IDLE);
  end

  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      main_q       <= M_POLL;
      cmd_q        <= C_IDLE;
      rd_cnt_q     <= '0;
      rx_byte_q    <= '0;
      rx_par_q     <= 1'b0;
      addr_q       <= A_STATUS;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      scan_valid_q <= 1'b0;
      scan_byte_q  <= '0;
      scan_par_q   <= 1'b0;
      stray_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      cbyte_q      <= '0;
      carg_q       <= '0;
      chas_q       <= 1'b0;
      status_q     <= '0;
      timer_q      <= '0;
      rs_q         <= '0;
    end else begin
      main_q       <= main_d;
      cmd_q        <= cmd_d;
      rd_cnt_q     <= rd_cnt_d;
      rx_byte_q    <= rx_byte_d;
      rx_par_q     <= rx_par_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      scan_valid_q <= scan_valid_d;
      scan_byte_q  <= scan_byte_d;
      scan_par_q   <= scan_par_d;
      stray_q      <= stray_d;
      cmd_ready_q  <= cmd_ready_d;
      cbyte_q      <= cbyte_d;
      carg_q       <= carg_d;
      chas_q       <= chas_d;
      status_q     <= status_d;
      timer_q      <= timer_d;
      rs_q         <= rs_d;
    end
  end

  assign cmd_ready            = cmd_ready_q;
  assign done                 = (cmd_q == C_FINISH);
  assign done_status          = status_q;
  assign scan_valid           = scan_valid_q;
  assign scan_byte            = scan_byte_q;
  assign scan_parity_err      = scan_par_q;
  assign stray_resp           = stray_q;
  assign mmio.address_mmio    = addr_q;
  assign mmio.data_write_mmio = wdata_q;
  assign mmio.is_mmio_write   = wr_q;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed bench: behavioural ps2_controller MMIO model with a 2-cycle read
// pipeline, scripted device replies, and monitors for scan/done/stray events.
module tb_ps2_command_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = 8'h00;
  logic       done;
  logic [1:0] done_status;
  logic       scan_valid;
  logic       scan_ready = 1'b1;
  logic [7:0] scan_byte;
  logic       scan_parity_err;
  logic       stray_resp;

  ps2_command_sequencer_if mmio_if();

  ps2_command_sequencer #(.ACK_TIMEOUT_CYCLES(100), .MAX_RESEND(3)) dut (
    .main_clk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .done(done), .done_status(done_status),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_byte(scan_byte),
    .scan_parity_err(scan_parity_err), .stray_resp(stray_resp),
    .mmio(mmio_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Controller model state
  logic [8:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] reply_script[$];
  logic [8:0] scan_log[$];
  logic [7:0] rd_p1 = 8'h00;
  logic [7:0] pend_byte = 8'h00;
  int cyc = 0, pops = 0, rd000 = 0, wr_viol = 0, gap = 2, pend = 0;
  int tx_wr_cyc = 0, done_cyc = 0, done_cnt = 0, stray_cnt = 0;
  logic [1:0] last_status = 2'd0;

  function automatic logic [7:0] reg_val(input logic [2:0] a);
    logic [8:0] f;
    f = (rx_q.size() != 0) ? rx_q[0] : 9'h000;
    case (a)
      3'b010:  return (rx_q.size() != 0) ? 8'h01 : 8'h00;
      3'b000:  return f[7:0];
      3'b100:  return {7'd0, f[8]};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_p1 <= reg_val(mmio_if.address_mmio);
    mmio_if.data_read_mmio <= rd_p1;
    if (mmio_if.address_mmio == 3'b000 && !mmio_if.is_mmio_write) rd000 <= rd000 + 1;
    if (pend == 1) rx_q.push_back({1'b0, pend_byte});
    if (pend > 0) pend <= pend - 1;
    if (mmio_if.is_mmio_write) begin
      if (gap < 2) wr_viol <= wr_viol + 1;
      gap <= 0;
      if (mmio_if.address_mmio == 3'b000) begin
        pops <= pops + 1;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
      end else if (mmio_if.address_mmio == 3'b001) begin
        tx_log.push_back(mmio_if.data_write_mmio);
        tx_wr_cyc <= cyc;
        if (reply_script.size() != 0) begin
          if (reply_script[0] != 8'h00) begin
            pend      <= 8;
            pend_byte <= reply_script[0];
          end
          void'(reply_script.pop_front());
        end
      end
    end else begin
      gap <= gap + 1;
    end
    if (scan_valid && scan_ready) scan_log.push_back({scan_parity_err, scan_byte});
    if (done) begin
      done_cnt    <= done_cnt + 1;
      last_status <= done_status;
      done_cyc    <= cyc;
    end
    if (stray_resp) stray_cnt <= stray_cnt + 1;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] b, input logic has, input logic [7:0] a);
    for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_byte = b; cmd_has_arg = has; cmd_arg = a; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_has_arg = 1'b0; cmd_arg = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == start; i++) @(negedge clk);
    check(tag, done_cnt - start, 1);
  endtask

  initial begin
    int base, p0, r0;
    logic [7:0] t5_bytes [5];
    logic       t5_par [5];
    t5_bytes = '{8'h1C, 8'h11, 8'h22, 8'h33, 8'h44};
    t5_par   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    cycles(3);
    check("rst_addr", mmio_if.address_mmio, 3'b010);
    check("rst_wr", mmio_if.is_mmio_write, 1'b0);
    check("rst_wdata", mmio_if.data_write_mmio, 8'h00);
    check("rst_scan_valid", scan_valid, 1'b0);
    check("rst_scan_byte", scan_byte, 8'h00);
    check("rst_done", {done, done_status}, 3'b000);
    check("rst_stray", stray_resp, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    cycles(2);
    check("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Device bytes drained with scan_ready high
    p0 = pops; base = scan_log.size();
    rx_q.push_back({1'b0, 8'h1C});
    rx_q.push_back({1'b1, 8'hF0});
    rx_q.push_back({1'b0, 8'h1C});
    for (int i = 0; i < 2000 && scan_log.size() < base + 3; i++) @(negedge clk);
    check("t1_count", scan_log.size() - base, 3);
    if (scan_log.size() >= base + 3) begin
      check("t1_b0", scan_log[base], {1'b0, 8'h1C});
      check("t1_b1", scan_log[base + 1], {1'b1, 8'hF0});
      check("t1_b2", scan_log[base + 2], {1'b0, 8'h1C});
    end
    cycles(20);
    check("t1_pops", pops - p0, 3);

    // Command with argument, ACK after each byte
    tx_log.delete(); base = scan_log.size();
    reply_script.push_back(8'hFA); reply_script.push_back(8'hFA);
    issue(8'hED, 1'b1, 8'h02);
    wait_done("t2_done");
    check("t2_ntx", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("t2_tx0", tx_log[0], 8'hED);
      check("t2_tx1", tx_log[1], 8'h02);
    end
    check("t2_status", last_status, 2'd0);
    check("t2_noscan", scan_log.size() - base, 0);

    // Resend limit: four RESENDs
    cycles(5);
    tx_log.delete();
    for (int i = 0; i < 4; i++) reply_script.push_back(8'hFE);
    issue(8'hFF, 1'b0, 8'h00);
    wait_done("t3_done");
    check("t3_ntx", tx_log.size(), 4);
    foreach (tx_log[i]) check("t3_tx", tx_log[i], 8'hFF);
    check("t3_status", last_status, 2'd1);

    // Timeout with no reply
    cycles(5);
    tx_log.delete();
    reply_script.push_back(8'h00);
    issue(8'hF4, 1'b0, 8'h00);
    wait_done("t4_done");
    check("t4_status", last_status, 2'd2);
    check("t4_ntx", tx_log.size(), 1);
    check("t4_latency_in_window",
          ((done_cyc - tx_wr_cyc) >= 100 && (done_cyc - tx_wr_cyc) <= 110), 1'b1);

    // Backpressure
    cycles(5);
    scan_ready = 1'b0;
    base = scan_log.size();
    for (int i = 0; i < 5; i++) rx_q.push_back({t5_par[i], t5_bytes[i]});
    for (int i = 0; i < 500 && !scan_valid; i++) @(negedge clk);
    check("t5_valid", scan_valid, 1'b1);
    p0 = pops; r0 = rd000;
    cycles(200);
    check("t5_hold_byte", scan_byte, 8'h1C);
    check("t5_hold_valid", scan_valid, 1'b1);
    check("t5_no_pop", pops - p0, 0);
    check("t5_no_read", rd000 - r0, 0);
    scan_ready = 1'b1;
    for (int i = 0; i < 3000 && scan_log.size() < base + 5; i++) @(negedge clk);
    check("t5_count", scan_log.size() - base, 5);
    if (scan_log.size() >= base + 5)
      for (int i = 0; i < 5; i++) check("t5_order", scan_log[base + i], {t5_par[i], t5_bytes[i]});

    // Device byte interleaved with the ACK during WAIT_CMD
    cycles(5);
    tx_log.delete(); base = scan_log.size();
    reply_script.push_back(8'h00);
    issue(8'hF2, 1'b0, 8'h00);
    for (int i = 0; i < 500 && tx_log.size() == 0; i++) @(negedge clk);
    check("t6_sent", tx_log.size(), 1);
    rx_q.push_back({1'b0, 8'h1C});
    rx_q.push_back({1'b0, 8'hFA});
    wait_done("t6_done");
    check("t6_status", last_status, 2'd0);
    check("t6_scan_n", scan_log.size() - base, 1);
    if (scan_log.size() > base) check("t6_scan", scan_log[base], {1'b0, 8'h1C});

    // Reset mid-WAIT, then a late ACK is stray
    cycles(5);
    tx_log.delete();
    reply_script.push_back(8'h00);
    issue(8'hF4, 1'b0, 8'h00);
    for (int i = 0; i < 500 && tx_log.size() == 0; i++) @(negedge clk);
    check("t7_sent", tx_log.size(), 1);
    cycles(5);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    p0 = stray_cnt; r0 = done_cnt;
    rx_q.push_back({1'b0, 8'hFA});
    cycles(150);
    check("t7_stray", stray_cnt - p0, 1);
    check("t7_no_done", done_cnt - r0, 0);
    check("t7_idle", cmd_ready, 1'b1);

    check("wr_gap_violations", wr_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end
endmodule
